// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the logic-analyzer host command decoder:
// frame constants, opcodes, parser/fetch state encodings and the frame check.
package uart_cmd_decoder_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_SET_MASK = 8'h01;
  localparam logic [7:0] OP_REARM    = 8'h02;
  localparam logic [7:0] OP_SET_DIV  = 8'h03;

  localparam logic [2:0] MASK_RESET = 3'b111;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    GET_OP  = 3'd1,
    GET_ARG = 3'd2,
    GET_SUM = 3'd3,
    EXEC    = 3'd4
  } parse_state_t;

  typedef enum logic [1:0] {
    F_READY  = 2'd0,
    F_STROBE = 2'd1,
    F_WAIT   = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] arg;
    logic [7:0] sum;
  } frame_t;

  // A frame executes only with a matching checksum and a known opcode.
  function automatic logic frame_ok(frame_t f);
    return ((f.op ^ f.arg) == f.sum) && (f.op <= OP_SET_DIV);
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Handshake between the UART receiver's one-byte buffer and the command decoder.
interface uart_cmd_decoder_if;
  logic       UART_rxempty;
  logic [7:0] UART_rx_data;
  logic       UART_uld_rx_data;

  modport master (output UART_rxempty, output UART_rx_data, input UART_uld_rx_data);
  modport slave  (input UART_rxempty, input UART_rx_data, output UART_uld_rx_data);
endinterface

// File: rtl/uart_rx_byte_fetch.sv
// Drains the receiver buffer: latches a byte, strobes the unload for one cycle,
// then waits for the empty flag to rise before it will take another byte.
//   state    | meaning
//   F_READY  | buffer may be read on the next non-empty cycle
//   F_STROBE | byte latched, unload strobe and byte_valid high
//   F_WAIT   | ignore the buffer until the empty flag has been seen high
module uart_rx_byte_fetch
  import uart_cmd_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxempty,
  input  logic [7:0] rx_data,
  output logic       uld,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  fetch_state_t state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= F_READY;
      byte_data <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == F_READY && !rxempty) byte_data <= rx_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      F_READY:  if (!rxempty) state_nxt = F_STROBE;
      F_STROBE: state_nxt = F_WAIT;
      F_WAIT:   if (rxempty) state_nxt = F_READY;
      default:  state_nxt = F_READY;
    endcase
  end

  assign uld        = (state == F_STROBE);
  assign byte_valid = (state == F_STROBE);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Frames 4-byte host commands (header, opcode, argument, checksum) and drives
// the capture configuration: trigger mask, divider select and re-arm request.
//   state   | meaning
//   HUNT    | discard bytes until the header arrives
//   GET_OP  | next byte is the opcode
//   GET_ARG | next byte is the argument
//   GET_SUM | next byte is the checksum
//   EXEC    | one cycle: apply or reject the frame
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter logic [7:0] HEADER         = HEADER_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_cmd_decoder_if.slave  uart,
  output logic [2:0]         triggerBlock_Mask,
  output logic [3:0]         clk_div_sel,
  output logic               rearm,
  output logic               cmd_done,
  output logic               cmd_error,
  output logic [7:0]         error_count,
  output logic [2:0]         state_debug
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] RELOAD = TW'(TIMEOUT_CYCLES);

  logic          byte_valid;
  logic [7:0]    byte_data;
  parse_state_t  state, state_nxt;
  frame_t        frame;
  logic [TW-1:0] timer;
  logic          in_get;
  logic          timed_out;
  logic          exec_ok;
  logic          err_evt;

  uart_rx_byte_fetch u_fetch (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxempty    (uart.UART_rxempty),
    .rx_data    (uart.UART_rx_data),
    .uld        (uart.UART_uld_rx_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  // A byte arriving on the expiry cycle takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    in_get    = (state == GET_OP) || (state == GET_ARG) || (state == GET_SUM);
    timed_out = in_get && !byte_valid && (timer == '0);
    exec_ok   = (state == EXEC) && frame_ok(frame);
    err_evt   = ((state == EXEC) && !frame_ok(frame)) || timed_out;
    case (state)
      HUNT:    if (byte_valid && byte_data == HEADER) state_nxt = GET_OP;
      GET_OP:  if (byte_valid) state_nxt = GET_ARG; else if (timed_out) state_nxt = HUNT;
      GET_ARG: if (byte_valid) state_nxt = GET_SUM; else if (timed_out) state_nxt = HUNT;
      GET_SUM: if (byte_valid) state_nxt = EXEC;    else if (timed_out) state_nxt = HUNT;
      EXEC:    state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer             <= '0;
      frame             <= '0;
      triggerBlock_Mask <= MASK_RESET;
      clk_div_sel       <= 4'd0;
      rearm             <= 1'b0;
      cmd_done          <= 1'b0;
      cmd_error         <= 1'b0;
      error_count       <= 8'd0;
    end else begin
      rearm     <= exec_ok && (frame.op == OP_REARM);
      cmd_done  <= exec_ok;
      cmd_error <= err_evt;
      if (err_evt && error_count != 8'hFF) error_count <= error_count + 8'd1;

      if (byte_valid)                  timer <= RELOAD;
      else if (in_get && timer != '0)  timer <= timer - 1'b1;

      if (byte_valid) begin
        case (state)
          GET_OP:  frame.op  <= byte_data;
          GET_ARG: frame.arg <= byte_data;
          GET_SUM: frame.sum <= byte_data;
          default: ;
        endcase
      end

      if (exec_ok) begin
        case (frame.op)
          OP_SET_MASK: triggerBlock_Mask <= frame.arg[2:0];
          OP_SET_DIV:  clk_div_sel       <= frame.arg[3:0];
          OP_NOP, OP_REARM: ;
          default: ;
        endcase
      end
    end
  end

  assign state_debug = state;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: a receiver model feeds bytes, a frame-level model
// predicts every output cycle by cycle, and directed cases pin literal results.
module tb_uart_cmd_decoder;

  localparam int T = 40;

  logic       clk;
  logic       rst_n;
  logic [2:0] mask;
  logic [3:0] div;
  logic       rearm, cmd_done, cmd_error;
  logic [7:0] error_count;
  logic [2:0] state_debug;

  uart_cmd_decoder_if uif();

  uart_cmd_decoder #(.HEADER(8'hA5), .TIMEOUT_CYCLES(T)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .uart              (uif.slave),
    .triggerBlock_Mask (mask),
    .clk_div_sel       (div),
    .rearm             (rearm),
    .cmd_done          (cmd_done),
    .cmd_error         (cmd_error),
    .error_count       (error_count),
    .state_debug       (state_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int strobes = 0;
  int sent = 0;
  int n_done = 0;
  int n_err = 0;
  int n_rearm = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- frame-level reference model ----------------
  typedef struct { int c; logic [7:0] b; } ev_t;
  ev_t        evq[$];
  logic [7:0] m_bytes[$];
  bit         m_in_frame;
  int         m_last;
  int         m_mask, m_div, m_errs;
  bit         p_valid;
  int         p_cyc;
  bit         p_done, p_err, p_rearm;
  int         p_mask, p_div;

  function automatic void model_reset();
    evq.delete();
    m_bytes.delete();
    m_in_frame = 0;
    m_last = 0;
    m_mask = 7;
    m_div = 0;
    m_errs = 0;
    p_valid = 0;
  endfunction

  // Byte accepted (unload strobe) in cycle c; a complete frame shows its effect at c+2.
  function automatic void model_byte(logic [7:0] b, int c);
    int op, arg, sum;
    if (!m_in_frame) begin
      if (b == 8'hA5) begin
        m_in_frame = 1;
        m_bytes.delete();
        m_last = c;
      end
    end else begin
      m_bytes.push_back(b);
      m_last = c;
      if (m_bytes.size() == 3) begin
        op = int'(m_bytes[0]);
        arg = int'(m_bytes[1]);
        sum = int'(m_bytes[2]);
        p_valid = 1;
        p_cyc = c + 2;
        p_done = 0; p_err = 0; p_rearm = 0;
        p_mask = m_mask; p_div = m_div;
        if (((op ^ arg) == sum) && op <= 3) begin
          p_done = 1;
          if (op == 1) p_mask = arg % 8;
          if (op == 2) p_rearm = 1;
          if (op == 3) p_div = arg % 16;
        end else begin
          p_err = 1;
        end
        m_in_frame = 0;
      end
    end
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    ev_t ev;
    bit  e_done, e_err, e_rearm;
    int  e_state;
    if (uif.UART_uld_rx_data) strobes++;
    if (cmd_done) n_done++;
    if (cmd_error) n_err++;
    if (rearm) n_rearm++;
    if (!rst_n) begin
      check("rst_mask", int'(mask), 7);
      check("rst_div", int'(div), 0);
      check("rst_errcnt", int'(error_count), 0);
      check("rst_pulses", int'({rearm, cmd_done, cmd_error}), 0);
      check("rst_state", int'(state_debug), 0);
    end else begin
      while (evq.size() > 0 && evq[0].c < cyc) begin
        ev = evq.pop_front();
        model_byte(ev.b, ev.c);
      end
      e_done = 0; e_err = 0; e_rearm = 0;
      if (m_in_frame && cyc == m_last + 2 + T) begin
        m_in_frame = 0;
        e_err = 1;
        if (m_errs < 255) m_errs++;
      end
      if (p_valid && cyc == p_cyc) begin
        e_done = p_done; e_err = p_err; e_rearm = p_rearm;
        m_mask = p_mask; m_div = p_div;
        if (p_err && m_errs < 255) m_errs++;
        p_valid = 0;
      end
      check("mask", int'(mask), m_mask);
      check("div", int'(div), m_div);
      check("errcnt", int'(error_count), m_errs);
      check("cmd_done", int'(cmd_done), int'(e_done));
      check("cmd_error", int'(cmd_error), int'(e_err));
      check("rearm", int'(rearm), int'(e_rearm));
      if (!p_valid) begin
        e_state = m_in_frame ? 1 + m_bytes.size() : 0;
        check("state", int'(state_debug), e_state);
      end
    end
  end

  // ---------------- receiver model ----------------
  task automatic send_byte(input logic [7:0] b, input int gap, input int hold);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    uif.UART_rx_data = b;
    uif.UART_rxempty = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!uif.UART_uld_rx_data && n < 10);
    check("fetch_latency", n, 1);
    if (uif.UART_uld_rx_data) evq.push_back('{c: cyc, b: b});
    sent++;
    repeat (hold) @(negedge clk);
    uif.UART_rxempty = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] arg, input logic [7:0] sum);
    send_byte(8'hA5, 0, 0);
    send_byte(op, 0, 0);
    send_byte(arg, 0, 0);
    send_byte(sum, 0, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic int rgap();
    if ($urandom_range(0, 15) == 0) return $urandom_range(T - 3, T);
    return $urandom_range(0, 3);
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, r0;
    int kind, nj;
    logic [7:0] op, arg, sum;
    rst_n = 1'b0;
    uif.UART_rxempty = 1'b1;
    uif.UART_rx_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("init_mask", int'(mask), 7);
    check("init_errcnt", int'(error_count), 0);

    // SET_MASK 5
    s0 = strobes; d0 = n_done;
    send_frame(8'h01, 8'h05, 8'h04);
    repeat (4) @(negedge clk);
    check("set_mask_val", int'(mask), 5);
    check("set_mask_done", n_done - d0, 1);
    check("set_mask_strobes", strobes - s0, 4);

    // leading junk then REARM
    d0 = n_done; r0 = n_rearm; s0 = n_err;
    send_byte(8'h00, 1, 0);
    send_byte(8'h33, 0, 0);
    send_frame(8'h02, 8'h00, 8'h02);
    repeat (4) @(negedge clk);
    check("rearm_pulses", n_rearm - r0, 1);
    check("rearm_done", n_done - d0, 1);
    check("junk_no_error", n_err - s0, 0);

    // bad checksum, then unknown opcode
    send_frame(8'h03, 8'h09, 8'h00);
    repeat (4) @(negedge clk);
    check("badsum_div", int'(div), 0);
    check("badsum_errcnt", int'(error_count), 1);
    send_frame(8'h07, 8'h00, 8'h07);
    repeat (4) @(negedge clk);
    check("badop_errcnt", int'(error_count), 2);

    // partial frame times out, next frame decodes
    send_byte(8'hA5, 0, 0);
    send_byte(8'h01, 0, 0);
    check("partial_state", int'(state_debug), 2);
    repeat (T + 5) @(negedge clk);
    check("timeout_errcnt", int'(error_count), 3);
    check("timeout_state", int'(state_debug), 0);
    send_frame(8'h01, 8'h02, 8'h03);
    repeat (4) @(negedge clk);
    check("after_timeout_mask", int'(mask), 2);

    // byte lands exactly on the expiry cycle
    send_byte(8'hA5, 0, 0);
    send_byte(8'h03, T - 2, 0);
    send_byte(8'h04, 0, 0);
    send_byte(8'h07, 0, 0);
    repeat (4) @(negedge clk);
    check("expiry_div", int'(div), 4);
    check("expiry_errcnt", int'(error_count), 3);

    // stale empty flag held low after each strobe
    s0 = strobes; d0 = n_done;
    send_byte(8'hA5, 0, 3);
    send_byte(8'h00, 0, 3);
    send_byte(8'h00, 0, 3);
    send_byte(8'h00, 0, 3);
    repeat (4) @(negedge clk);
    check("stale_strobes", strobes - s0, 4);
    check("stale_done", n_done - d0, 1);

    // reset mid-frame
    send_byte(8'hA5, 0, 0);
    send_byte(8'h01, 0, 0);
    pulse_reset();
    @(negedge clk);
    check("midrst_mask", int'(mask), 7);
    check("midrst_state", int'(state_debug), 0);
    send_frame(8'h01, 8'h06, 8'h07);
    repeat (4) @(negedge clk);
    check("postrst_mask", int'(mask), 6);

    // randomized traffic against the model
    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 9);
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 3), 0);
      op = (kind == 8) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      arg = 8'($urandom_range(0, 255));
      sum = op ^ arg;
      if (kind == 6 || kind == 7) sum = sum ^ 8'($urandom_range(1, 255));
      send_byte(8'hA5, $urandom_range(0, 3), $urandom_range(0, 2));
      send_byte(op, rgap(), $urandom_range(0, 2));
      if (kind == 9) begin
        repeat (T + 5) @(negedge clk);
      end else begin
        send_byte(arg, rgap(), $urandom_range(0, 2));
        send_byte(sum, rgap(), $urandom_range(0, 2));
        repeat (3) @(negedge clk);
      end
    end
    repeat (T + 5) @(negedge clk);

    // error counter saturation
    for (int k = 0; k < 256; k++) send_frame(8'h01, 8'h00, 8'h00);
    repeat (4) @(negedge clk);
    check("sat_errcnt", int'(error_count), 255);
    send_frame(8'h05, 8'h00, 8'h05);
    repeat (4) @(negedge clk);
    check("sat_nowrap", int'(error_count), 255);

    repeat (4) @(negedge clk);
    check("strobes_total", strobes, sent);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
